// File: rtl/dec_lut_req_sched.sv
// Request scheduler for the clocked 12-bit LUT decoder: buffers codewords, issues one
// decode at a time with a timeout. Define DEC_SCHED_STATS_EN to add hit/miss counters.
module dec_lut_req_sched #(
  parameter int unsigned W_BITS     = 25,
  parameter int unsigned N_BITS     = 13,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 4200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_BITS-1:0] in_w,
  output logic [W_BITS-1:0] dec_w,
  output logic              dec_start,
  input  logic              dec_found,
  input  logic [N_BITS-1:0] dec_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_BITS-1:0] out_w,
  output logic [N_BITS-1:0] out_n,
  output logic              out_miss
`ifdef DEC_SCHED_STATS_EN
  ,
  output logic [15:0]       stat_total,
  output logic [15:0]       stat_miss
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUT} state_e;

  state_e              state_q, state_d;
  logic [W_BITS-1:0]   mem_q [FIFO_DEPTH];
  logic [W_BITS-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                in_ready_q, in_ready_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [W_BITS-1:0]   dec_w_q, dec_w_d;
  logic                dec_start_q, dec_start_d;
  logic                out_valid_q, out_valid_d;
  logic [W_BITS-1:0]   out_w_q, out_w_d;
  logic [N_BITS-1:0]   out_n_q, out_n_d;
  logic                out_miss_q, out_miss_d;
  logic                push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  // FIFO bookkeeping; pointers wrap naturally since the depth is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_w;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  // Scheduler FSM: launch, wait for found or timeout, hold the result until accepted
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    dec_w_d     = dec_w_q;
    dec_start_d = 1'b0;
    out_valid_d = out_valid_q;
    out_w_d     = out_w_q;
    out_n_d     = out_n_q;
    out_miss_d  = out_miss_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          dec_w_d     = mem_q[rd_ptr_q];
          dec_start_d = 1'b1;
          state_d     = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (dec_found) begin
          out_n_d     = dec_n;
          out_w_d     = dec_w_q;
          out_miss_d  = 1'b0;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          out_n_d     = '0;
          out_w_d     = dec_w_q;
          out_miss_d  = 1'b1;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      tmo_q       <= '0;
      dec_w_q     <= '0;
      dec_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_w_q     <= '0;
      out_n_q     <= '0;
      out_miss_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      tmo_q       <= tmo_d;
      dec_w_q     <= dec_w_d;
      dec_start_q <= dec_start_d;
      out_valid_q <= out_valid_d;
      out_w_q     <= out_w_d;
      out_n_q     <= out_n_d;
      out_miss_q  <= out_miss_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign dec_w     = dec_w_q;
  assign dec_start = dec_start_q;
  assign out_valid = out_valid_q;
  assign out_w     = out_w_q;
  assign out_n     = out_n_q;
  assign out_miss  = out_miss_q;

`ifdef DEC_SCHED_STATS_EN
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_miss_q, stat_miss_d;

  // Saturating counters bumped on each result handshake
  always_comb begin
    stat_total_d = stat_total_q;
    stat_miss_d  = stat_miss_q;
    if (out_valid_q && out_ready) begin
      if (stat_total_q != 16'hFFFF) stat_total_d = stat_total_q + 16'd1;
      if (out_miss_q && (stat_miss_q != 16'hFFFF)) stat_miss_d = stat_miss_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_total_q <= '0;
      stat_miss_q  <= '0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_miss_q  <= stat_miss_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_miss  = stat_miss_q;
`endif

endmodule
